// File: rtl/ir_key_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ir_key_line_buffer
//  Purpose  : Turns IR remote key events into single-character writes for a
//             one-line LCD (valid/ready write port), with repeat suppression,
//             backspace, clear-line and a raw-code shift register for 7-seg.
//  Revision : 1.0  initial release
// ============================================================================
module ir_key_line_buffer #(
    parameter int          LINE_LEN  = 16,
    parameter int          SEG_BYTES = 1,
    parameter int          HOLD_CYC  = 5_000_000,
    parameter int          WRAP      = 1,
    parameter logic [7:0]  BS_CODE   = 8'h11,
    parameter logic [7:0]  CLR_CODE  = 8'h12,
    localparam int         PW        = $clog2(LINE_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             ir_code,
    input  logic                   ir_valid,
    output logic                   lcd_wr_valid,
    input  logic                   lcd_wr_ready,
    output logic [PW-1:0]          lcd_wr_pos,
    output logic [7:0]             lcd_wr_char,
    output logic [PW-1:0]          cursor,
    output logic                   busy,
    output logic                   key_dropped,
    output logic                   overflow,
    output logic [8*SEG_BYTES-1:0] seg_code
);

    localparam int            HW          = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] c_hold_load = HW'(HOLD_CYC - 1);
    localparam logic [PW-1:0] c_last_col  = PW'(LINE_LEN - 1);
    localparam logic [PW-1:0] c_pos_one   = PW'(1);
    localparam logic [7:0]    c_space     = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nx_state;
    logic                  r_ir_valid_d;
    logic                  r_armed;
    logic [HW-1:0]         r_hold;
    logic [7:0]            r_last_code;
    logic                  r_full;
    logic                  r_op_bs;
    logic                  r_lcd_wr_valid;
    logic [PW-1:0]         r_lcd_wr_pos;
    logic [7:0]            r_lcd_wr_char;
    logic [PW-1:0]         r_cursor;
    logic                  r_busy;
    logic                  r_key_dropped;
    logic                  r_overflow;
    logic [8*SEG_BYTES-1:0] r_seg_code;

    logic                  w_event;
    logic                  w_suppress;
    logic                  w_is_bs;
    logic                  w_is_clr;
    logic                  w_is_char;
    logic [7:0]            w_char;
    logic                  w_mapped;
    logic                  w_take;
    logic                  w_drop;
    logic                  w_xfer;
    logic                  w_nx_valid;
    logic [PW-1:0]         w_nx_pos;
    logic [7:0]            w_nx_char;
    logic [PW-1:0]         w_nx_cursor;
    logic                  w_nx_full;
    logic                  w_nx_overflow;
    logic                  w_nx_op_bs;

    // A level already high when reset releases must be seen low before it
    // can produce an event, hence the arming flag.
    assign w_event    = ir_valid & ~r_ir_valid_d & r_armed;
    assign w_suppress = (ir_code == r_last_code) && (r_hold != '0);
    assign w_mapped   = w_is_char | w_is_bs | w_is_clr;
    assign w_take     = w_event & ~w_suppress & w_mapped & (r_state == IDLE);
    assign w_drop     = w_event & ~w_suppress & w_mapped & (r_state != IDLE);
    assign w_xfer     = r_lcd_wr_valid & lcd_wr_ready;

    // Key code classification and character map; control keys take priority.
    always_comb begin
        w_is_bs   = (ir_code == BS_CODE);
        w_is_clr  = (ir_code == CLR_CODE) && !w_is_bs;
        w_is_char = 1'b0;
        w_char    = c_space;
        if (ir_code <= 8'h09) begin
            w_is_char = 1'b1;
            w_char    = 8'h30 + ir_code;
        end else begin
            case (ir_code)
                8'h0F:   begin w_is_char = 1'b1; w_char = 8'h41; end
                8'h13:   begin w_is_char = 1'b1; w_char = 8'h42; end
                8'h10:   begin w_is_char = 1'b1; w_char = 8'h43; end
                default: begin w_is_char = 1'b0; w_char = c_space; end
            endcase
        end
        if (w_is_bs || w_is_clr) begin
            w_is_char = 1'b0;
        end
    end

    // Edge detector and arming flag for the IR level strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_valid_d <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_ir_valid_d <= ir_valid;
            r_armed      <= r_armed | ~ir_valid;
        end
    end

    // Repeat-suppression window and last accepted code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_last_code <= 8'hFF;
        end else if (w_take) begin
            r_hold      <= c_hold_load;
            r_last_code <= ir_code;
        end else if (r_hold != '0) begin
            r_hold      <= r_hold - HW'(1);
        end
    end

    // Raw-code display register: every event shifts in, whatever its fate.
    generate
        if (SEG_BYTES == 1) begin : g_seg_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       r_seg_code <= '0;
                else if (w_event) r_seg_code <= ir_code;
            end
        end else begin : g_seg_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       r_seg_code <= '0;
                else if (w_event) r_seg_code <= {r_seg_code[8*SEG_BYTES-9:0], ir_code};
            end
        end
    endgenerate

    // Next-state and next-output logic for the write sequencer.
    always_comb begin
        w_nx_state    = r_state;
        w_nx_valid    = r_lcd_wr_valid;
        w_nx_pos      = r_lcd_wr_pos;
        w_nx_char     = r_lcd_wr_char;
        w_nx_cursor   = r_cursor;
        w_nx_full     = r_full;
        w_nx_overflow = r_overflow;
        w_nx_op_bs    = r_op_bs;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    if (w_is_clr) begin
                        w_nx_state = CLEAR;
                        w_nx_valid = 1'b1;
                        w_nx_pos   = '0;
                        w_nx_char  = c_space;
                    end else if (w_is_bs) begin
                        // Nothing to erase at column 0 unless the line is full.
                        if ((r_cursor != '0) || r_full) begin
                            w_nx_state = WRITE;
                            w_nx_valid = 1'b1;
                            w_nx_pos   = r_full ? r_cursor : (r_cursor - c_pos_one);
                            w_nx_char  = c_space;
                            w_nx_op_bs = 1'b1;
                        end
                    end else if ((WRAP == 0) && r_full) begin
                        w_nx_overflow = 1'b1;
                    end else begin
                        w_nx_state = WRITE;
                        w_nx_valid = 1'b1;
                        w_nx_pos   = r_cursor;
                        w_nx_char  = w_char;
                        w_nx_op_bs = 1'b0;
                    end
                end
            end
            WRITE: begin
                if (w_xfer) begin
                    w_nx_state = IDLE;
                    w_nx_valid = 1'b0;
                    if (r_op_bs) begin
                        w_nx_cursor = r_lcd_wr_pos;
                        w_nx_full   = 1'b0;
                    end else if (r_cursor == c_last_col) begin
                        if (WRAP != 0) w_nx_cursor = '0;
                        else           w_nx_full   = 1'b1;
                    end else begin
                        w_nx_cursor = r_cursor + c_pos_one;
                    end
                end
            end
            CLEAR: begin
                if (w_xfer) begin
                    if (r_lcd_wr_pos == c_last_col) begin
                        w_nx_state    = IDLE;
                        w_nx_valid    = 1'b0;
                        w_nx_cursor   = '0;
                        w_nx_full     = 1'b0;
                        w_nx_overflow = 1'b0;
                    end else begin
                        w_nx_pos = r_lcd_wr_pos + c_pos_one;
                    end
                end
            end
            default: begin
                w_nx_state = IDLE;
                w_nx_valid = 1'b0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_lcd_wr_valid <= 1'b0;
            r_lcd_wr_pos   <= '0;
            r_lcd_wr_char  <= c_space;
            r_cursor       <= '0;
            r_full         <= 1'b0;
            r_overflow     <= 1'b0;
            r_op_bs        <= 1'b0;
            r_busy         <= 1'b0;
            r_key_dropped  <= 1'b0;
        end else begin
            r_state        <= w_nx_state;
            r_lcd_wr_valid <= w_nx_valid;
            r_lcd_wr_pos   <= w_nx_pos;
            r_lcd_wr_char  <= w_nx_char;
            r_cursor       <= w_nx_cursor;
            r_full         <= w_nx_full;
            r_overflow     <= w_nx_overflow;
            r_op_bs        <= w_nx_op_bs;
            r_busy         <= (w_nx_state != IDLE);
            r_key_dropped  <= w_drop;
        end
    end

    assign lcd_wr_valid = r_lcd_wr_valid;
    assign lcd_wr_pos   = r_lcd_wr_pos;
    assign lcd_wr_char  = r_lcd_wr_char;
    assign cursor       = r_cursor;
    assign busy         = r_busy;
    assign key_dropped  = r_key_dropped;
    assign overflow     = r_overflow;
    assign seg_code     = r_seg_code;

endmodule
`default_nettype wire

// File: tb/tb_ir_key_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_key_line_buffer
//  Purpose  : Self-checking bench; instance A is a 16-column wrapping line,
//             instance B a 4-column saturating line.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ir_key_line_buffer;

    typedef struct packed { logic [7:0] pos; logic [7:0] ch; } wr_t;
    typedef struct { logic [7:0] code; bit wr; logic [7:0] ch; } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [7:0]  a_code, b_code;
    logic        a_vld, b_vld;

    logic        a_valid, a_busy, a_kd, a_ovf;
    logic [3:0]  a_pos, a_cursor;
    logic [7:0]  a_char;
    logic [15:0] a_seg;
    logic        b_valid, b_busy, b_kd, b_ovf;
    logic [1:0]  b_pos, b_cursor;
    logic [7:0]  b_char;
    logic [7:0]  b_seg;

    int checks = 0;
    int errors = 0;
    int kd_a   = 0;
    int kd_b   = 0;
    int sel    = 0;
    wr_t qa[$];
    wr_t qb[$];

    always #5 clk = ~clk;

    ir_key_line_buffer #(.LINE_LEN(16), .SEG_BYTES(2), .HOLD_CYC(20), .WRAP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .ir_code(a_code), .ir_valid(a_vld),
        .lcd_wr_valid(a_valid), .lcd_wr_ready(ready), .lcd_wr_pos(a_pos),
        .lcd_wr_char(a_char), .cursor(a_cursor), .busy(a_busy),
        .key_dropped(a_kd), .overflow(a_ovf), .seg_code(a_seg));

    ir_key_line_buffer #(.LINE_LEN(4), .SEG_BYTES(1), .HOLD_CYC(20), .WRAP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .ir_code(b_code), .ir_valid(b_vld),
        .lcd_wr_valid(b_valid), .lcd_wr_ready(ready), .lcd_wr_pos(b_pos),
        .lcd_wr_char(b_char), .cursor(b_cursor), .busy(b_busy),
        .key_dropped(b_kd), .overflow(b_ovf), .seg_code(b_seg));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int which, input int pos, input logic [7:0] ch);
        wr_t w;
        w.pos = 8'(pos);
        w.ch  = ch;
        if (which == 0) qa.push_back(w);
        else            qb.push_back(w);
    endtask

    // Scoreboard: each accepted write is popped and compared; while stalled,
    // the request must stay put.
    task automatic monitor();
        bit         a_st = 0, b_st = 0;
        logic [7:0] a_sp = 0, a_sc = 0, b_sp = 0, b_sc = 0;
        wr_t        w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_st = 0;
                b_st = 0;
            end else begin
                if (a_st) begin
                    chk("a_stall_valid", a_valid, 1);
                    chk("a_stall_pos", a_pos, a_sp);
                    chk("a_stall_char", a_char, a_sc);
                end
                if (a_valid && ready) begin
                    if (qa.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL a_unexpected_write pos=%0h char=%0h required=none", a_pos, a_char);
                    end else begin
                        w = qa.pop_front();
                        chk("a_wr_pos", a_pos, w.pos);
                        chk("a_wr_char", a_char, w.ch);
                    end
                end
                a_st = a_valid && !ready; a_sp = 8'(a_pos); a_sc = a_char;
                if (b_st) begin
                    chk("b_stall_valid", b_valid, 1);
                    chk("b_stall_pos", b_pos, b_sp);
                    chk("b_stall_char", b_char, b_sc);
                end
                if (b_valid && ready) begin
                    if (qb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected_write pos=%0h char=%0h required=none", b_pos, b_char);
                    end else begin
                        w = qb.pop_front();
                        chk("b_wr_pos", b_pos, w.pos);
                        chk("b_wr_char", b_char, w.ch);
                    end
                end
                b_st = b_valid && !ready; b_sp = 8'(b_pos); b_sc = b_char;
                if (a_kd) kd_a++;
                if (b_kd) kd_b++;
            end
        end
    endtask

    task automatic press(input logic [7:0] c);
        @(posedge clk); #1;
        if (sel == 0) begin a_code = c; a_vld = 1'b1; end
        else          begin b_code = c; b_vld = 1'b1; end
        @(posedge clk); #1;
        a_vld = 1'b0;
        b_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (((sel == 0) ? a_busy : b_busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, (sel == 0) ? a_busy : b_busy, 0);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_valid"},  a_valid, 0);
        chk({tag, "_pos"},    a_pos, 0);
        chk({tag, "_char"},   a_char, 8'h20);
        chk({tag, "_cursor"}, a_cursor, 0);
        chk({tag, "_busy"},   a_busy, 0);
        chk({tag, "_kd"},     a_kd, 0);
        chk({tag, "_ovf"},    a_ovf, 0);
        chk({tag, "_seg"},    a_seg, 0);
    endtask

    initial begin
        vec_t tbl[7];
        int   cur_a;
        int   kd_before;
        logic [7:0] prev_a;

        tbl[0] = '{8'h09, 1'b1, 8'h39};
        tbl[1] = '{8'h0F, 1'b1, 8'h41};
        tbl[2] = '{8'h13, 1'b1, 8'h42};
        tbl[3] = '{8'h10, 1'b1, 8'h43};
        tbl[4] = '{8'h00, 1'b1, 8'h30};
        tbl[5] = '{8'h33, 1'b0, 8'h20};
        tbl[6] = '{8'h08, 1'b1, 8'h38};

        fork
            monitor();
            begin
                #2_000_000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset, with A's strobe already high before release.
        rst_n = 1'b0; ready = 1'b1;
        a_code = 8'h07; a_vld = 1'b1;
        b_code = 8'h00; b_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_a("rst");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("held_strobe_seg", a_seg, 0);
        chk("held_strobe_busy", a_busy, 0);
        a_vld = 1'b0;
        repeat (2) @(posedge clk);

        // Single key.
        sel = 0;
        push(0, 0, 8'h35);
        press(8'h05);
        wait_idle("k05_idle");
        @(posedge clk); #1;
        chk("k05_cursor", a_cursor, 1);
        chk("k05_seg", a_seg[7:0], 8'h05);
        cur_a = 1;
        prev_a = 8'h05;

        // Key map table.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr) begin
                push(0, cur_a, tbl[i].ch);
                cur_a = (cur_a + 1) % 16;
            end
            press(tbl[i].code);
            wait_idle("tbl_idle");
            @(posedge clk); #1;
            chk("tbl_cursor", a_cursor, cur_a);
            chk("tbl_seg", a_seg, {prev_a, tbl[i].code});
            prev_a = tbl[i].code;
        end

        // Stalled write holds for 10 cycles.
        ready = 1'b0;
        push(0, cur_a, 8'h31);
        press(8'h01);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_valid", a_valid, 1);
        ready = 1'b1;
        wait_idle("stall_idle");
        cur_a++;
        @(posedge clk); #1;
        chk("stall_cursor", a_cursor, cur_a);
        chk("stall_queue", qa.size(), 0);

        // Repeat suppression.
        kd_before = kd_a;
        push(0, cur_a, 8'h33);
        press(8'h03);
        wait_idle("rep1_idle");
        press(8'h03);
        repeat (3) @(posedge clk);
        #1;
        cur_a++;
        chk("rep2_cursor", a_cursor, cur_a);
        chk("rep2_seg", a_seg, 16'h0303);
        chk("rep2_no_drop", kd_a, kd_before);
        repeat (30) @(posedge clk);
        push(0, cur_a, 8'h33);
        press(8'h03);
        wait_idle("rep3_idle");
        @(posedge clk); #1;
        cur_a++;
        chk("rep3_cursor", a_cursor, cur_a);

        // Backspace mid-line.
        push(0, cur_a - 1, 8'h20);
        press(8'h11);
        wait_idle("bs_idle");
        @(posedge clk); #1;
        cur_a--;
        chk("bs_cursor", a_cursor, cur_a);

        // Clear with a key arriving mid-clear.
        for (int i = 0; i < 16; i++) push(0, i, 8'h20);
        kd_before = kd_a;
        press(8'h12);
        press(8'h07);
        wait_idle("clr_idle");
        @(posedge clk); #1;
        chk("clr_drop_pulse", kd_a - kd_before, 1);
        chk("clr_cursor", a_cursor, 0);
        chk("clr_seg", a_seg, 16'h1207);
        chk("clr_queue", qa.size(), 0);

        // Saturating line on instance B.
        sel = 1;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) push(1, i - 1, 8'h30 + 8'(i));
            press(8'(i));
            wait_idle("b_key_idle");
        end
        @(posedge clk); #1;
        chk("b_ovf", b_ovf, 1);
        chk("b_full_cursor", b_cursor, 3);
        chk("b_seg", b_seg, 8'h05);
        push(1, 3, 8'h20);
        press(8'h11);
        wait_idle("b_bs_idle");
        @(posedge clk); #1;
        chk("b_bs_cursor", b_cursor, 3);
        push(1, 3, 8'h36);
        press(8'h06);
        wait_idle("b_k6_idle");
        @(posedge clk); #1;
        chk("b_k6_cursor", b_cursor, 3);
        chk("b_ovf_sticky", b_ovf, 1);
        chk("b_queue", qb.size(), 0);

        // Reset in the middle of a clear.
        sel = 0;
        for (int i = 0; i < 16; i++) push(0, i, 8'h20);
        press(8'h12);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_a("midclr");
        qa.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("midclr_hold_valid", a_valid, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        press(8'h20);
        repeat (4) @(posedge clk);
        #1;
        chk("unmapped_busy", a_busy, 0);
        chk("unmapped_cursor", a_cursor, 0);
        chk("unmapped_seg", a_seg[7:0], 8'h20);
        chk("final_qa", qa.size(), 0);
        chk("final_qb", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_key_line_buffer.md
IR_KEY_LINE_BUFFER -- requirements
Module: ir_key_line_buffer

Interface
REQ-001 The block SHALL have these parameters:
- LINE_LEN, 16: LCD line length in characters, range 2..64.
- SEG_BYTES, 1: number of raw IR codes shown on the 7-seg outputs, range 1..4.
- HOLD_CYC, 5_000_000: repeat-suppression window in clk cycles, minimum 1.
- WRAP, 1: cursor behaviour at end of line; 1 = wrap, 0 = saturate.
- BS_CODE, 8'h11: backspace key code.
- CLR_CODE, 8'h12: clear key code.

REQ-002 The block SHALL have these ports (PW = $clog2(LINE_LEN)):
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- ir_code, input, 8: decoded IR key code; stable while ir_valid is high.
- ir_valid, input, 1: level strobe from the IR receiver.
- lcd_wr_valid, output, 1: character-write request.
- lcd_wr_ready, input, 1: LCD controller accepts the current write.
- lcd_wr_pos, output, PW: column to write.
- lcd_wr_char, output, 8: ASCII character to write.
- cursor, output, PW: next write column.
- busy, output, 1: FSM is not in IDLE.
- key_dropped, output, 1: one-cycle pulse, key discarded because busy.
- overflow, output, 1: sticky; a character was lost with WRAP=0.
- seg_code, output, 8*SEG_BYTES: latched raw codes, newest in [7:0].

Function
REQ-003 Event detection:
- ir_valid SHALL be registered once.
- An event SHALL be the rising edge ir_valid & ~ir_valid_d in cycle N.
- ir_code SHALL be captured in that same cycle N.

REQ-004 seg_code SHALL shift left by 8 and load the captured code in [7:0] at N+1 on every event, including suppressed, unmapped and dropped events.

REQ-005 Repeat suppression:
- An event whose code equals the last accepted code, while the hold counter is nonzero, SHALL be ignored, with no write and no key_dropped pulse.
- The hold counter SHALL load HOLD_CYC-1 on each accepted event.
- The hold counter SHALL decrement to 0 and saturate there.

REQ-006 Key map:
- 8'h00..8'h09 -> 8'h30..8'h39.
- 8'h0F -> 8'h41.
- 8'h13 -> 8'h42.
- 8'h10 -> 8'h43.
- All other codes, except BS_CODE and CLR_CODE, SHALL be ignored silently, with no write and no cursor change.

REQ-007 The FSM SHALL have exactly the states IDLE, WRITE and CLEAR.
- Events SHALL be decoded only in IDLE.
- An event that is not suppressed and not unmapped and arrives while busy=1 SHALL be discarded and SHALL pulse key_dropped at N+1.

REQ-008 Character key in IDLE:
- At N+1 the block SHALL enter WRITE, with lcd_wr_pos=cursor, lcd_wr_char=the mapped char, and lcd_wr_valid=1 from N+1.
- Exception: if WRAP=0 and cursor==LINE_LEN-1 after the last column has already been written, the block SHALL stay in IDLE and set overflow.

REQ-009 Handshake:
- lcd_wr_valid, lcd_wr_pos and lcd_wr_char SHALL be held stable until a cycle where lcd_wr_valid & lcd_wr_ready.
- The transfer SHALL complete in that cycle.
- lcd_wr_valid SHALL not drop without a transfer.

REQ-010 Cursor after a character transfer:
- cursor SHALL increment.
- At LINE_LEN-1: WRAP=1 -> 0; WRAP=0 -> cursor stays at LINE_LEN-1 and a full flag is set.
- The full flag SHALL clear on backspace or clear.
- The FSM SHALL return to IDLE the cycle after the transfer.

REQ-011 BS_CODE:
- Cursor 0 with full flag clear SHALL be a no-op.
- Otherwise the block SHALL enter WRITE with pos = (full ? cursor : cursor-1) and char 8'h20.
- On transfer, cursor SHALL become that pos and the full flag SHALL clear.

REQ-012 CLR_CODE:
- The block SHALL enter CLEAR and issue LINE_LEN writes of 8'h20 at pos 0..LINE_LEN-1 in order.
- lcd_wr_valid MAY stay high back-to-back.
- After the last transfer: cursor=0, full clear, overflow clear, return to IDLE.

REQ-013 busy SHALL equal (state != IDLE), registered.

REQ-014 All outputs SHALL be registered, with no combinational path from lcd_wr_ready to lcd_wr_valid.

Reset
REQ-015 On rst_n low, the block SHALL asynchronously set:
- state=IDLE, cursor=0, lcd_wr_valid=0, lcd_wr_pos=0, lcd_wr_char=8'h20.
- busy=0, key_dropped=0, overflow=0, full=0.
- seg_code=0, hold counter=0, last accepted code=8'hFF, ir_valid_d=0.

REQ-016 Reset asserted mid-WRITE or mid-CLEAR SHALL abandon the write, with lcd_wr_valid low immediately.

REQ-017 After rst_n release, ir_valid already high SHALL NOT create an event until it is seen low and then high again.

Verification
REQ-018 ready tied 1; ir_code 8'h05 pulse -> write pos 0, char 8'h35; cursor=1; seg_code[7:0]=8'h05.

REQ-019 ready held 0 for 10 cycles -> valid, pos and char stable for 10 cycles, then exactly one transfer.

REQ-020 LINE_LEN=4, WRAP=0; 5 distinct keys -> 4 writes, overflow=1, cursor=3; then BS_CODE -> ' ' written at pos 3, cursor=3.

REQ-021 Same key twice within HOLD_CYC -> one write; third press after HOLD_CYC -> second write.

REQ-022 CLR_CODE with ready=1 -> 16 consecutive writes of 8'h20 at pos 0..15; a key sent mid-clear -> key_dropped pulse; afterwards cursor=0.

REQ-023 rst_n asserted during CLEAR -> lcd_wr_valid=0 and all REQ-015 values hold; unmapped code 8'h20 -> no write, seg_code updated.
